swipt_rx_demod: RTL and testbench
=================================

// Module: swipt_rx_demod
// PURPOSE
//  Receiver-side counterpart of the SWIPT H-bridge driver: the power link carries data as a per-mille pulse length l per half-cycle.
//  Takes the comparator output of the rectified receive coil, deglitches it and measures the rectified period and the high time.
//  Recovers l = high*500/period with a serial divider, slices it against a threshold into a data bit and flags carrier presence.
// PARAMETERS
//  CNT_W      16    width of period/high counters (cycles)
//  DEGLITCH   3     cycles a synchronized level must hold before it is accepted
//  MIN_PERIOD 32    shortest accepted rectified period (cycles); must exceed divider latency
//  TIMEOUT    4095  period-counter value that declares carrier loss
//  L_THRESH   300   bit_out=1 when l_meas >= L_THRESH
//  HIGH_ADJ   0     cycles added to high time before divide (TX dead-time compensation)
// PORTS
//  clk          in   1      system clock (50 MHz nominal)
//  nrst         in   1      asynchronous active-low reset
//  swipt_in     in   1      raw comparator output, async to clk, high while coil voltage is above threshold
//  l_meas       out  12     recovered pulse length, per mille of TX period (0..500)
//  l_valid      out  1      1-cycle strobe, l_meas/bit_out/period_meas updated
//  bit_out      out  1      data slice of l_meas
//  period_meas  out  CNT_W  last accepted rectified period (cycles)
//  carrier_ok   out  1      carrier present
//  err_cnt      out  8      saturating count of rejected periods (< MIN_PERIOD)
// BEHAVIOUR
//  Reset: every output 0; FSM = S_WAIT; counters, synchronizer and filter are cleared (filtered level 0).
//  Input: 2-FF synchronizer, then filter: filtered level changes only after DEGLITCH consecutive equal samples differing from it.
//  rise_evt: cycle in which the filtered level goes 0->1. Shorter pulses never reach the counters.
//  Counters: per_cnt increments every cycle, saturating at TIMEOUT; hi_cnt increments while filtered=1, saturating.
//  On rise_evt both are reloaded to 1 (hi_cnt to 1 because the level is already high in that cycle).
//  FSM S_WAIT: on rise_evt, reload counters and go to S_MEAS. Nothing is measured.
//  FSM S_MEAS, rise_evt with per_cnt >= MIN_PERIOD: capture per_cnt and hi_cnt+HIGH_ADJ, start divider, reload counters.
//  FSM S_MEAS, rise_evt with per_cnt < MIN_PERIOD: drop the sample, err_cnt+1 (saturating at 255), reload counters.
//  FSM S_MEAS, per_cnt == TIMEOUT: carrier_ok<=0, go to S_WAIT. A stuck-high or stuck-low input both time out.
//  Divider: numerator = hi*500 (CNT_W+9 bits), denominator = captured period; restoring, 1 quotient bit per cycle, CNT_W+9 cycles.
//  Quotient is clamped to 500 and truncated to 12 bits.
//  Latency: l_valid is high exactly CNT_W+10 cycles after rise_evt (26 at default). l_meas, bit_out and period_meas update in that cycle.
//  carrier_ok <= 1 together with the first l_valid after S_WAIT.
//  Since MIN_PERIOD > divider latency, a capture never occurs while the divider is busy.
//  Timeout during a divide: the divide still completes and l_valid fires. carrier_ok stays 0 until the next valid sequence.
//  Reset mid-divide: result discarded, no l_valid after release. The first l_valid needs two accepted rising edges.
//  Outputs other than l_valid hold their value between strobes.
// TESTING
//  T1 clk 50 MHz; swipt_in period 250, high 200 cycles (TX 100 kHz, l=400) -> l_meas=400, bit_out=1, period_meas=250, carrier_ok=1 at 2nd edge+26.
//  T2 period 250, high 50 -> l_meas=100, bit_out=0. Alternate 200/50 each period -> bit_out toggles each l_valid.
//  T3 2-cycle glitches injected in low and high phases of T1 -> no extra rise_evt, values unchanged, err_cnt=0.
//  T4 period 20, high 10 for 5 periods -> no l_valid, err_cnt=4; err_cnt saturates at 255 under sustained input.
//  T5 T1, then hold swipt_in low for 5000 cycles -> carrier_ok falls at per_cnt=4095. The next edge only arms; l_valid returns at the following edge.
//  T6 nrst pulse low 3 cycles during a divide -> all outputs 0 immediately. No l_valid until the 2nd accepted edge after release.

Source files
------------

// File: rtl/swipt_rx_demod.sv
// SWIPT receiver demodulator: deglitches the rectified-coil comparator, measures period
// and high time, and recovers the per-mille pulse length with a serial restoring divider.
module swipt_rx_demod #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned DEGLITCH   = 3,
   parameter int unsigned MIN_PERIOD = 32,
   parameter int unsigned TIMEOUT    = 4095,
   parameter int unsigned L_THRESH   = 300,
   parameter int unsigned HIGH_ADJ   = 0
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             swipt_in,
   output logic [11:0]      l_meas,
   output logic             l_valid,
   output logic             bit_out,
   output logic [CNT_W-1:0] period_meas,
   output logic             carrier_ok,
   output logic [7:0]       err_cnt
);

   localparam int unsigned NUM_W = CNT_W + 9;
   localparam int unsigned DG_W  = (DEGLITCH > 1) ? $clog2(DEGLITCH) : 1;
   localparam int unsigned IT_W  = $clog2(NUM_W + 1);

   localparam logic [DG_W-1:0]  DG_LAST = DG_W'(DEGLITCH - 1);
   localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] HADJ    = CNT_W'(HIGH_ADJ);
   localparam logic [11:0]      L_TH    = 12'(L_THRESH);
   localparam logic [NUM_W-1:0] L_MAX   = NUM_W'(500);

   typedef enum logic {S_WAIT, S_MEAS} state_t;

   state_t            state_q, state_d;
   logic              sync1_q, sync1_d, sync2_q, sync2_d;
   logic              filt_q, filt_d, filt_dly_q, filt_dly_d;
   logic [DG_W-1:0]   dg_cnt_q, dg_cnt_d;
   logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
   logic [NUM_W-1:0]  num_q, num_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [CNT_W-1:0]  den_q, den_d;
   logic [IT_W-1:0]   it_q, it_d;
   logic              busy_q, busy_d;
   logic              fresh_q, fresh_d;
   logic [11:0]       l_meas_q, l_meas_d;
   logic              l_valid_q, l_valid_d;
   logic              bit_out_q, bit_out_d;
   logic [CNT_W-1:0]  period_meas_q, period_meas_d;
   logic              carrier_ok_q, carrier_ok_d;
   logic [7:0]        err_cnt_q, err_cnt_d;

   logic              rise_evt;
   logic              tmo_evt;
   logic [CNT_W-1:0]  hi_adj;
   logic [CNT_W:0]    rem_sh;
   logic              ge;
   logic [NUM_W-1:0]  num_nx;
   logic [11:0]       q_clamp;

   always_comb begin
      sync1_d    = swipt_in;
      sync2_d    = sync1_q;
      filt_d     = filt_q;
      dg_cnt_d   = '0;
      filt_dly_d = filt_q;
      if (sync2_q != filt_q) begin
         if (dg_cnt_q == DG_LAST) filt_d = sync2_q;
         else                     dg_cnt_d = dg_cnt_q + DG_W'(1);
      end
      rise_evt = filt_q & ~filt_dly_q;

      per_cnt_d = (per_cnt_q == TMO) ? per_cnt_q : per_cnt_q + CNT_W'(1);
      hi_cnt_d  = (filt_q && hi_cnt_q != '1) ? hi_cnt_q + CNT_W'(1) : hi_cnt_q;
      if (rise_evt) begin
         per_cnt_d = CNT_W'(1);
         hi_cnt_d  = CNT_W'(1);
      end

      // one restoring-division step; the num register shifts the quotient in from the LSB
      rem_sh  = {rem_q, num_q[NUM_W-1]};
      ge      = (rem_sh >= {1'b0, den_q});
      num_nx  = {num_q[NUM_W-2:0], ge};
      q_clamp = (num_nx > L_MAX) ? 12'd500 : num_nx[11:0];
      hi_adj  = hi_cnt_q + HADJ;

      state_d       = state_q;
      num_d         = num_q;
      rem_d         = rem_q;
      den_d         = den_q;
      it_d          = it_q;
      busy_d        = busy_q;
      fresh_d       = fresh_q;
      l_meas_d      = l_meas_q;
      l_valid_d     = 1'b0;
      bit_out_d     = bit_out_q;
      period_meas_d = period_meas_q;
      carrier_ok_d  = carrier_ok_q;
      err_cnt_d     = err_cnt_q;
      tmo_evt       = 1'b0;

      if (busy_q) begin
         rem_d  = ge ? (rem_sh[CNT_W-1:0] - den_q) : rem_sh[CNT_W-1:0];
         num_d  = num_nx;
         it_d   = it_q - IT_W'(1);
         if (it_q == IT_W'(1)) begin
            busy_d        = 1'b0;
            l_valid_d     = 1'b1;
            l_meas_d      = q_clamp;
            bit_out_d     = (q_clamp >= L_TH);
            period_meas_d = den_q;
         end
      end

      case (state_q)
         S_WAIT: begin
            if (rise_evt) state_d = S_MEAS;
         end
         S_MEAS: begin
            if (rise_evt) begin
               if (per_cnt_q >= MIN_P) begin
                  num_d   = {9'd0, hi_adj} * NUM_W'(500);
                  rem_d   = '0;
                  den_d   = per_cnt_q;
                  it_d    = IT_W'(NUM_W);
                  busy_d  = 1'b1;
                  fresh_d = 1'b1;
               end else if (err_cnt_q != '1) begin
                  err_cnt_d = err_cnt_q + 8'd1;
               end
            end else if (per_cnt_q == TMO) begin
               tmo_evt = 1'b1;
               state_d = S_WAIT;
            end
         end
         default: state_d = S_WAIT;
      endcase

      // a timeout voids any in-flight result's claim to carrier presence
      if (tmo_evt) begin
         fresh_d      = 1'b0;
         carrier_ok_d = 1'b0;
      end else if (l_valid_d && fresh_q) begin
         carrier_ok_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q       <= S_WAIT;
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         filt_q        <= 1'b0;
         filt_dly_q    <= 1'b0;
         dg_cnt_q      <= '0;
         per_cnt_q     <= '0;
         hi_cnt_q      <= '0;
         num_q         <= '0;
         rem_q         <= '0;
         den_q         <= '0;
         it_q          <= '0;
         busy_q        <= 1'b0;
         fresh_q       <= 1'b0;
         l_meas_q      <= '0;
         l_valid_q     <= 1'b0;
         bit_out_q     <= 1'b0;
         period_meas_q <= '0;
         carrier_ok_q  <= 1'b0;
         err_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         filt_q        <= filt_d;
         filt_dly_q    <= filt_dly_d;
         dg_cnt_q      <= dg_cnt_d;
         per_cnt_q     <= per_cnt_d;
         hi_cnt_q      <= hi_cnt_d;
         num_q         <= num_d;
         rem_q         <= rem_d;
         den_q         <= den_d;
         it_q          <= it_d;
         busy_q        <= busy_d;
         fresh_q       <= fresh_d;
         l_meas_q      <= l_meas_d;
         l_valid_q     <= l_valid_d;
         bit_out_q     <= bit_out_d;
         period_meas_q <= period_meas_d;
         carrier_ok_q  <= carrier_ok_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign l_meas      = l_meas_q;
   assign l_valid     = l_valid_q;
   assign bit_out     = bit_out_q;
   assign period_meas = period_meas_q;
   assign carrier_ok  = carrier_ok_q;
   assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_swipt_rx_demod.sv
// Directed bench for swipt_rx_demod: hand-computed l_meas/bit/period/carrier/err expectations.
module tb_swipt_rx_demod;

   logic        clk = 1'b0;
   logic        nrst;
   logic        swipt_in;
   logic [11:0] l_meas;
   logic        l_valid;
   logic        bit_out;
   logic [15:0] period_meas;
   logic        carrier_ok;
   logic [7:0]  err_cnt;

   int nvec  = 0;
   int nfail = 0;
   int cyc   = 0;
   int nvalid = 0;
   int valid_cyc = 0;
   int last_rise = 0;
   int n0 = 0;
   int t5_rise = 0;

   swipt_rx_demod #(
      .CNT_W(16), .DEGLITCH(3), .MIN_PERIOD(32), .TIMEOUT(4095), .L_THRESH(300), .HIGH_ADJ(0)
   ) dut (
      .clk(clk), .nrst(nrst), .swipt_in(swipt_in), .l_meas(l_meas), .l_valid(l_valid),
      .bit_out(bit_out), .period_meas(period_meas), .carrier_ok(carrier_ok), .err_cnt(err_cnt)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // strobe recorder: count l_valid pulses and note the cycle of the latest one
   always @(negedge clk) begin
      if (l_valid) begin
         nvalid    <= nvalid + 1;
         valid_cyc <= cyc;
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 75000", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse(input int hi, input int per);
      last_rise = cyc;
      swipt_in = 1'b1;
      repeat (hi) @(negedge clk);
      swipt_in = 1'b0;
      repeat (per - hi) @(negedge clk);
   endtask

   task automatic glitch_period();
      last_rise = cyc;
      swipt_in = 1'b1; repeat (80)  @(negedge clk);
      swipt_in = 1'b0; repeat (2)   @(negedge clk);
      swipt_in = 1'b1; repeat (118) @(negedge clk);
      swipt_in = 1'b0; repeat (20)  @(negedge clk);
      swipt_in = 1'b1; repeat (2)   @(negedge clk);
      swipt_in = 1'b0; repeat (28)  @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_l_meas"},  32'(l_meas), 0);
      check({tag, "_l_valid"}, 32'(l_valid), 0);
      check({tag, "_bit"},     32'(bit_out), 0);
      check({tag, "_period"},  32'(period_meas), 0);
      check({tag, "_carrier"}, 32'(carrier_ok), 0);
      check({tag, "_err"},     32'(err_cnt), 0);
   endtask

   initial begin
      nrst = 1'b0;
      swipt_in = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      nrst = 1'b1;
      repeat (5) @(negedge clk);

      // T1: 250/200 -> l=400; first edge only arms
      pulse(200, 250);
      check("t1_arm_no_valid", 32'(nvalid), 0);
      check("t1_arm_carrier", 32'(carrier_ok), 0);
      pulse(200, 250);
      check("t1_nvalid", 32'(nvalid), 1);
      check("t1_latency", 32'(valid_cyc - last_rise), 31);
      check("t1_l_meas", 32'(l_meas), 400);
      check("t1_bit", 32'(bit_out), 1);
      check("t1_period", 32'(period_meas), 250);
      check("t1_carrier", 32'(carrier_ok), 1);
      check("t1_err", 32'(err_cnt), 0);
      pulse(200, 250);

      // T2: each edge reports the period that just ended
      pulse(50, 250);
      pulse(50, 250);
      check("t2_l_100", 32'(l_meas), 100);
      check("t2_bit_0", 32'(bit_out), 0);
      pulse(200, 250);
      pulse(50, 250);
      check("t2_alt_l_400", 32'(l_meas), 400);
      check("t2_alt_bit_1", 32'(bit_out), 1);
      pulse(200, 250);
      check("t2_alt_bit_0", 32'(bit_out), 0);

      // threshold boundary and truncation
      pulse(150, 250);
      pulse(149, 250);
      check("thr_l_300", 32'(l_meas), 300);
      check("thr_bit_1", 32'(bit_out), 1);
      pulse(111, 333);
      check("thr_l_298", 32'(l_meas), 298);
      check("thr_bit_0", 32'(bit_out), 0);
      pulse(200, 250);
      check("trunc_l_166", 32'(l_meas), 166);
      check("trunc_period", 32'(period_meas), 333);

      // T3: 2-cycle glitches are swallowed by the filter
      n0 = nvalid;
      glitch_period();
      glitch_period();
      pulse(200, 250);
      check("t3_nvalid", 32'(nvalid), 32'(n0 + 3));
      check("t3_l_meas", 32'(l_meas), 400);
      check("t3_period", 32'(period_meas), 250);
      check("t3_err", 32'(err_cnt), 0);

      // T5: carrier loss exactly at per_cnt == 4095
      t5_rise = last_rise;
      n0 = nvalid;
      while (cyc < t5_rise + 4100) @(negedge clk);
      check("t5_carrier_before", 32'(carrier_ok), 1);
      @(negedge clk);
      check("t5_carrier_after", 32'(carrier_ok), 0);
      repeat (900) @(negedge clk);
      check("t5_no_valid_idle", 32'(nvalid), 32'(n0));
      check("t5_hold_l", 32'(l_meas), 400);
      pulse(200, 250);
      check("t5_arm_no_valid", 32'(nvalid), 32'(n0));
      check("t5_arm_carrier", 32'(carrier_ok), 0);
      pulse(200, 250);
      check("t5_nvalid", 32'(nvalid), 32'(n0 + 1));
      check("t5_latency", 32'(valid_cyc - last_rise), 31);
      check("t5_l_meas", 32'(l_meas), 400);
      check("t5_carrier", 32'(carrier_ok), 1);

      // T4: short periods rejected, MIN_PERIOD boundary, saturation
      n0 = nvalid;
      repeat (4200) @(negedge clk);
      check("t4_timeout_carrier", 32'(carrier_ok), 0);
      repeat (5) pulse(10, 20);
      check("t4_err_4", 32'(err_cnt), 4);
      check("t4_no_valid", 32'(nvalid), 32'(n0));
      pulse(10, 31);
      check("t4_err_20", 32'(err_cnt), 5);
      pulse(10, 32);
      check("t4_err_31", 32'(err_cnt), 6);
      pulse(200, 250);
      check("t4_min_nvalid", 32'(nvalid), 32'(n0 + 1));
      check("t4_min_l_156", 32'(l_meas), 156);
      check("t4_min_period", 32'(period_meas), 32);
      check("t4_min_carrier", 32'(carrier_ok), 1);
      check("t4_min_err", 32'(err_cnt), 6);
      repeat (260) pulse(10, 20);
      check("t4_err_sat", 32'(err_cnt), 255);
      check("t4_sat_l_meas", 32'(l_meas), 400);

      // T6: asynchronous reset during a divide discards the result
      pulse(200, 250);
      pulse(200, 250);
      check("t6_pre_l_meas", 32'(l_meas), 400);
      n0 = nvalid;
      last_rise = cyc;
      swipt_in = 1'b1;
      repeat (20) @(negedge clk);
      swipt_in = 1'b0;
      repeat (7) @(negedge clk);
      nrst = 1'b0;
      #1;
      check_all_zero("t6_rst");
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      repeat (250) @(negedge clk);
      check("t6_no_valid", 32'(nvalid), 32'(n0));
      check("t6_l_zero", 32'(l_meas), 0);
      pulse(200, 250);
      check("t6_arm_no_valid", 32'(nvalid), 32'(n0));
      check("t6_arm_carrier", 32'(carrier_ok), 0);
      pulse(200, 250);
      check("t6_nvalid", 32'(nvalid), 32'(n0 + 1));
      check("t6_l_meas", 32'(l_meas), 400);
      check("t6_carrier", 32'(carrier_ok), 1);
      check("t6_err", 32'(err_cnt), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
